// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin write arbiter that lets one of four requesters own the FIFO
// write port for a burst of beats. A burst ends on the requester's last
// flag, after MAX_BURST accepted beats, or when the owner drops its request
// while the FIFO has room. A full FIFO stalls the burst without losing the
// grant.
//
// Ports
//   wr_clk    in   clock, all state updates on the rising edge
//   wr_rst_n  in   synchronous active-low reset
//   req       in   [3:0]     per-requester beat valid
//   req_last  in   [3:0]     per-requester last-beat marker
//   req_data  in   [4*DW-1:0] requester i data at [i*DW +: DW]
//   full      in   FIFO full flag
//   gnt       out  [3:0]     registered one-hot grant, zero when no owner
//   wr_en     out  FIFO write enable (combinational)
//   wr_data   out  [DW-1:0]  FIFO write data (combinational)
//   owner     out  [1:0]     current or most recent grantee
//   busy      out  high while a burst is in progress
module fifo_wr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 8
) (
  input  logic            wr_clk,
  input  logic            wr_rst_n,
  input  logic [3:0]      req,
  input  logic [3:0]      req_last,
  input  logic [4*DW-1:0] req_data,
  input  logic            full,
  output logic [3:0]      gnt,
  output logic            wr_en,
  output logic [DW-1:0]   wr_data,
  output logic [1:0]      owner,
  output logic            busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t        r_state;
  logic [3:0]    r_gnt;
  logic [1:0]    r_owner;
  logic [1:0]    r_rr_last;
  logic [CW-1:0] r_beat_cnt;

  logic          w_xfer;
  logic          w_owner_req;
  logic          w_owner_last;
  logic          w_accept;
  logic          w_burst_end;
  logic          w_abandon;
  logic [1:0]    w_pick;
  logic [DW-1:0] w_owner_data;

  // First set request bit scanning upward from the requester after the
  // most recent owner, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = last + 2'd1;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    w_owner_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_owner == 2'(i)) w_owner_data = req_data[i*DW +: DW];
    end
  end

  assign w_xfer       = (r_state == XFER);
  assign w_owner_req  = req[r_owner];
  assign w_owner_last = req_last[r_owner];
  assign w_pick       = rr_pick(req, r_rr_last);

  // A full FIFO blocks the beat; it never counts as abandonment.
  assign w_accept    = w_xfer & w_owner_req & ~full;
  assign w_burst_end = w_accept &
                       (w_owner_last | (r_beat_cnt == CW'(MAX_BURST - 1)));
  assign w_abandon   = w_xfer & ~w_owner_req & ~full;

  assign wr_en   = w_accept;
  assign wr_data = w_xfer ? w_owner_data : '0;
  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign busy    = w_xfer;

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= 4'b0000;
      r_owner    <= 2'd0;
      r_rr_last  <= 2'd3;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_owner    <= w_pick;
            r_gnt      <= 4'b0001 << w_pick;
            r_beat_cnt <= '0;
            r_state    <= XFER;
          end else begin
            r_gnt <= 4'b0000;
          end
        end
        XFER: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
          end
          if (w_burst_end || w_abandon) begin
            r_state   <= IDLE;
            r_gnt     <= 4'b0000;
            r_rr_last <= r_owner;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: fixed vector table, directed multi-cycle
// sequences and a randomized run, all compared with a burst-level model.
module tb_fifo_wr_arbiter;

  localparam int DW        = 8;
  localparam int MAX_BURST = 8;

  logic            wr_clk = 1'b0;
  logic            wr_rst_n;
  logic [3:0]      req;
  logic [3:0]      req_last;
  logic [4*DW-1:0] req_data;
  logic            full;
  logic [3:0]      gnt;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [1:0]      owner;
  logic            busy;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: who owns the port, how many beats taken, who went last.
  int m_xfer  = 0;
  int m_owner = 0;
  int m_last  = 3;
  int m_beats = 0;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .wr_clk   (wr_clk),
    .wr_rst_n (wr_rst_n),
    .req      (req),
    .req_last (req_last),
    .req_data (req_data),
    .full     (full),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .owner    (owner),
    .busy     (busy)
  );

  typedef struct {
    logic          rst_n;
    logic [3:0]    req;
    logic [3:0]    last;
    logic          full;
    logic [31:0]   data;
    logic [3:0]    e_gnt;
    logic          e_wren;
    logic [DW-1:0] e_wdata;
    logic [1:0]    e_owner;
    logic          e_busy;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare current DUT outputs with the model, after inputs have settled.
  task automatic eval_model();
    logic [3:0]    e_gnt;
    logic          e_wren;
    logic [DW-1:0] e_data;
    #2;
    e_gnt  = (m_xfer != 0) ? (4'b0001 << m_owner) : 4'b0000;
    e_wren = (m_xfer != 0) && req[m_owner] && !full;
    e_data = (m_xfer != 0) ? req_data[m_owner*DW +: DW] : '0;
    chk("model_gnt",     32'(gnt),     32'(e_gnt));
    chk("model_wr_en",   32'(wr_en),   32'(e_wren));
    chk("model_wr_data", 32'(wr_data), 32'(e_data));
    chk("model_owner",   32'(owner),   32'(m_owner));
    chk("model_busy",    32'(busy),    32'(m_xfer));
  endtask

  // Advance the model by the rules for this cycle's inputs, then clock.
  task automatic adv();
    if (!wr_rst_n) begin
      m_xfer = 0; m_owner = 0; m_last = 3; m_beats = 0;
    end else if (m_xfer == 0) begin
      if (req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (req[(m_last + k) % 4]) begin
            m_owner = (m_last + k) % 4;
            break;
          end
        end
        m_xfer  = 1;
        m_beats = 0;
      end
    end else if (req[m_owner] && !full) begin
      m_beats++;
      if (req_last[m_owner] || m_beats == MAX_BURST) begin
        m_xfer = 0;
        m_last = m_owner;
      end
    end else if (!req[m_owner] && !full) begin
      m_xfer = 0;
      m_last = m_owner;
    end
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0; req = 4'b0; req_last = 4'b0; full = 1'b0; req_data = '0;
    adv();
    wr_rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int acc;
    int fcnt;
    logic full_now;
    logic [DW-1:0] got [$];

    //                rst  req      last     full  data          gnt      wren  wdata  own   busy
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0100, 4'b0000, 1'b0, 32'h44332211, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'b0100, 4'b0000, 1'b0, 32'h00A10000, 4'b0100, 1'b1, 8'hA1, 2'd2, 1'b1};
    tbl[3]  = '{1'b1, 4'b0100, 4'b0000, 1'b0, 32'h00A20000, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1};
    tbl[4]  = '{1'b1, 4'b0100, 4'b0100, 1'b0, 32'h00A30000, 4'b0100, 1'b1, 8'hA3, 2'd2, 1'b1};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 32'h55555555, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};
    tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};
    tbl[7]  = '{1'b1, 4'b1011, 4'b0000, 1'b1, 32'h99999999, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};
    tbl[8]  = '{1'b1, 4'b1011, 4'b0000, 1'b1, 32'hB1000000, 4'b1000, 1'b0, 8'hB1, 2'd3, 1'b1};
    tbl[9]  = '{1'b1, 4'b1011, 4'b1000, 1'b0, 32'hB2000000, 4'b1000, 1'b1, 8'hB2, 2'd3, 1'b1};
    tbl[10] = '{1'b1, 4'b1011, 4'b0000, 1'b0, 32'h000000C0, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0};
    tbl[11] = '{1'b1, 4'b1011, 4'b0001, 1'b0, 32'h000000C1, 4'b0001, 1'b1, 8'hC1, 2'd0, 1'b1};
    tbl[12] = '{1'b1, 4'b1011, 4'b0000, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[13] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0000D100, 4'b0010, 1'b0, 8'hD1, 2'd1, 1'b1};
    tbl[14] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};

    wr_rst_n = 1'b0; req = 4'b0; req_last = 4'b0; full = 1'b0; req_data = '0;
    adv();
    adv();

    for (int i = 0; i < 15; i++) begin
      wr_rst_n = tbl[i].rst_n;
      req      = tbl[i].req;
      req_last = tbl[i].last;
      full     = tbl[i].full;
      req_data = tbl[i].data;
      eval_model();
      chk($sformatf("row%0d_gnt", i),     32'(gnt),     32'(tbl[i].e_gnt));
      chk($sformatf("row%0d_wr_en", i),   32'(wr_en),   32'(tbl[i].e_wren));
      chk($sformatf("row%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].e_wdata));
      chk($sformatf("row%0d_owner", i),   32'(owner),   32'(tbl[i].e_owner));
      chk($sformatf("row%0d_busy", i),    32'(busy),    32'(tbl[i].e_busy));
      adv();
    end

    // All four requesting single-beat bursts: 0,1,2,3,0 with idle gaps.
    do_reset();
    req = 4'b1111; req_last = 4'b1111; full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_data = $urandom;
      eval_model();
      chk($sformatf("rr_gnt%0d", i), 32'(gnt),
          (i % 2 == 0) ? 32'h0 : 32'(4'b0001 << ((i / 2) % 4)));
      adv();
    end

    // Requester 1 without last flag runs to MAX_BURST; 2 waits its turn.
    do_reset();
    req = 4'b0110; req_last = 4'b0000; full = 1'b0;
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      req_data = $urandom;
      eval_model();
      if (i <= 9) pulses += int'(wr_en);
      if (i == 9) chk("maxburst_idle_busy", 32'(busy), 32'h0);
      if (i == 10) chk("maxburst_next_gnt", 32'(gnt), 32'h4);
      adv();
    end
    chk("maxburst_pulses", 32'(pulses), 32'(MAX_BURST));

    // Five full cycles after beat 2; requester scribbles data while stalled.
    do_reset();
    acc = 0; fcnt = 0;
    for (int c = 0; c < 40; c++) begin
      full_now = (acc == 2 && fcnt < 5);
      full     = full_now;
      req      = 4'b0001;
      req_last = (acc == 4) ? 4'b0001 : 4'b0000;
      req_data = full_now ? 32'h000000EE : 32'(8'h10 + 8'(acc));
      eval_model();
      if (full_now) begin
        fcnt++;
        chk("full_gnt_held", 32'(gnt), 32'h1);
        chk("full_no_wr_en", 32'(wr_en), 32'h0);
      end
      if (wr_en) begin
        got.push_back(wr_data);
        acc++;
      end
      adv();
      if (acc == 5) break;
    end
    chk("full_total_beats", 32'(acc), 32'd5);
    chk("full_stall_cycles", 32'(fcnt), 32'd5);
    chk("full_written_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("full_beat%0d_data", i), 32'(got[i]), 32'(8'h10 + 8'(i)));

    // Owner 3 abandons after two beats; pending requester 0 is next.
    do_reset();
    req = 4'b1000; req_last = 4'b0000; full = 1'b0; req_data = 32'h12345678;
    eval_model(); adv();
    eval_model();
    chk("abandon_gnt3", 32'(gnt), 32'h8);
    chk("abandon_beat1", 32'(wr_en), 32'h1);
    adv();
    eval_model();
    chk("abandon_beat2", 32'(wr_en), 32'h1);
    adv();
    req = 4'b0001;
    eval_model();
    chk("abandon_gnt_kept", 32'(gnt), 32'h8);
    chk("abandon_no_wr_en", 32'(wr_en), 32'h0);
    adv();
    eval_model();
    chk("abandon_idle_busy", 32'(busy), 32'h0);
    chk("abandon_idle_gnt", 32'(gnt), 32'h0);
    adv();
    eval_model();
    chk("abandon_next_gnt0", 32'(gnt), 32'h1);
    adv();

    // Reset in the middle of a burst, then 0 wins over 3.
    do_reset();
    req = 4'b1000; req_last = 4'b0000; full = 1'b0; req_data = 32'hCAFE0000;
    eval_model(); adv();
    eval_model();
    chk("midrst_busy_before", 32'(busy), 32'h1);
    adv();
    wr_rst_n = 1'b0;
    eval_model(); adv();
    wr_rst_n = 1'b1; req = 4'b1001;
    eval_model();
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_wr_en", 32'(wr_en), 32'h0);
    chk("midrst_owner", 32'(owner), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    adv();
    eval_model();
    chk("midrst_first_gnt", 32'(gnt), 32'h1);
    adv();

    // Randomized traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      wr_rst_n = ($urandom_range(0, 63) != 0);
      req      = 4'($urandom_range(0, 15));
      req_last = 4'($urandom) & 4'($urandom);
      full     = ($urandom_range(0, 3) == 0);
      req_data = $urandom;
      eval_model();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
